// File: rtl/wait_state_ram_if.sv
// Bus bundle for wait_state_ram: access request side (master) and the RAM side (slave).
interface wait_state_ram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              memory_w;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              memory_ready;
  logic              error;

  modport master (
    output req, memory_w, addr, wdata,
    input  rdata, memory_ready, error
  );

  modport slave (
    input  req, memory_w, addr, wdata,
    output rdata, memory_ready, error
  );
endinterface

// File: rtl/wait_state_ram.sv
// Word RAM whose reads and writes complete after a fixed number of wait cycles.
// An access is triggered by an address change or by req, depending on TRIG_MODE.
module wait_state_ram #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256,
  parameter int RD_WAIT   = 0,
  parameter int WR_WAIT   = 1,
  parameter int TRIG_MODE = 0
) (
  input logic             clk,
  input logic             rst,
  wait_state_ram_if.slave bus
);
  // state   | meaning
  // ST_IDLE | no access pending; watching for a trigger
  // ST_WAIT | access latched; counting wait cycles, completes when cnt_q == 0
  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]       RD_CNT    = 8'(RD_WAIT);
  localparam logic [7:0]       WR_CNT    = 8'(WR_WAIT);
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  logic              trigger;
  logic              in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH];

  assign trigger  = (TRIG_MODE == 1) ? bus.req : (bus.addr != last_addr_q);
  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
  assign idx      = addr_q[IDX_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    last_addr_d = last_addr_q;
    rdata_d     = rdata_q;
    ready_d     = ready_q;
    error_d     = error_q;
    mem_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          addr_d      = bus.addr;
          we_d        = bus.memory_w;
          wdata_d     = bus.wdata;
          last_addr_d = bus.addr;
          cnt_d       = bus.memory_w ? WR_CNT : RD_CNT;
          ready_d     = 1'b0;
          error_d     = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          // out-of-range accesses still complete on time but touch nothing
          if (!in_range) begin
            rdata_d = '0;
            error_d = 1'b1;
          end else if (we_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      last_addr_q <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      last_addr_q <= last_addr_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  // Contents survive reset; a reset on the completion edge aborts the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx] <= wdata_q;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.memory_ready = ready_q;
  assign bus.error        = error_q;
endmodule

// File: doc/wait_state_ram.md
WAIT_STATE_RAM -- requirements
Module: wait_state_ram

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, data word width.
REQ-002 SHALL provide parameter ADDR_W, default 16, address width.
REQ-003 SHALL provide parameter DEPTH, default 256, words stored; legal range 1..2^ADDR_W.
REQ-004 SHALL provide parameter RD_WAIT, default 0, extra wait cycles per read; legal range 0..255.
REQ-005 SHALL provide parameter WR_WAIT, default 1, extra wait cycles per write; legal range 0..255.
REQ-006 SHALL provide parameter TRIG_MODE, default 0; 0 = access starts on address change, 1 = access starts on req.
REQ-007 SHALL have ports:
  clk  input  1  clock; all state changes on rising edge.
  rst  input  1  reset; synchronous, active-high.
  req  input  1  access strobe; used only when TRIG_MODE=1.
  memory_w  input  1  1 = write access, 0 = read access; sampled at trigger.
  addr  input  ADDR_W  word address; sampled at trigger.
  wdata  input  DATA_W  write data; sampled at trigger.
  rdata  output  DATA_W  read data; registered.
  memory_ready  output  1  1 = idle or access complete; 0 = access in progress.
  error  output  1  1 = last completed access was out of range.

Function
REQ-008 SHALL implement FSM states IDLE and WAIT.
REQ-009 Trigger in IDLE SHALL be defined as:
  - TRIG_MODE=0: addr != last_addr.
  - TRIG_MODE=1: req=1.
REQ-010 On trigger at edge T0, the block SHALL:
  - latch addr, memory_w and wdata;
  - load last_addr <= addr;
  - load cnt <= WR_WAIT if memory_w=1, else RD_WAIT;
  - drive memory_ready <= 0 and error <= 0;
  - enter WAIT.
REQ-011 In WAIT with cnt != 0, the block SHALL decrement cnt by 1 per edge and hold outputs.
REQ-012 In WAIT with cnt == 0, the block SHALL perform the latched access, drive memory_ready <= 1 and return to IDLE on that edge.
REQ-013 memory_ready SHALL therefore be low for exactly WAIT+1 cycles, where WAIT is the value of RD_WAIT or WR_WAIT selected at trigger.
REQ-014 A read SHALL load rdata with mem[latched addr] on the completion edge; rdata SHALL hold all other times.
REQ-015 A write SHALL store the latched wdata on the completion edge and leave rdata unchanged.
REQ-016 Triggers while in WAIT SHALL be ignored.
REQ-017 In TRIG_MODE=0, an address change during WAIT SHALL NOT be latched; it SHALL be detected in IDLE on the first edge after completion.
REQ-018 Changes to memory_w, addr or wdata during WAIT SHALL NOT affect the access in progress.
REQ-019 Out-of-range access (latched addr >= DEPTH) SHALL complete with normal latency, and on the completion edge SHALL:
  - suppress the write;
  - set rdata <= 0;
  - set error <= 1.
REQ-020 error SHALL hold until the next trigger.
REQ-021 In TRIG_MODE=1, req held high SHALL start back-to-back accesses: first trigger evaluated on the edge after completion.
REQ-022 Simultaneous trigger and rst SHALL resolve to reset.
REQ-023 Counter width SHALL be 8 bits; cnt SHALL never wrap.

Reset
REQ-024 On rst=1 at a rising edge, the block SHALL set:
  - state=IDLE, cnt=0;
  - memory_ready=1, rdata=0, error=0;
  - last_addr=0.
REQ-025 rst during WAIT SHALL abort the access; an aborted write SHALL NOT modify memory.
REQ-026 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-027 Defaults, TRIG_MODE=0: after rst, set addr=0x0005, memory_w=1, wdata=0xBEEF -> memory_ready low for exactly 2 cycles, then high.
REQ-028 Defaults: after REQ-027, set addr=0x0007 (read), then addr=0x0005 (read) -> memory_ready low 1 cycle each; rdata=0xBEEF after the second read.
REQ-029 RD_WAIT=3, TRIG_MODE=1: pulse req with addr=0x0005, then toggle addr and pulse req during WAIT -> memory_ready low exactly 4 cycles; exactly one access performed.
REQ-030 DEPTH=256: write 0x1234 to addr=0x0100 -> error=1 and rdata=0 at completion; a subsequent read of addr=0x0000 is unchanged and error returns to 0.
REQ-031 WR_WAIT=4: assert rst 2 cycles into a write of 0xAAAA to addr=0x0003 -> memory_ready=1 on the next edge; a read of addr=0x0003 returns its prior value.
REQ-032 TRIG_MODE=1, req held high with addr fixed at 0x0002 (read): memory_ready pattern SHALL repeat 0,1 per access, with no two consecutive low cycles.
